ascii_ps2_tx: RTL and testbench

Keyboard-side PS/2 transmitter: takes ASCII characters from a byte handshake and emits the matching Set-2 make/break scancode sequence as PS/2 device frames on `ps2_clk`/`ps2_data`. It is the inverse of the scancode-to-ASCII receive path. It lets the text editor and video pipeline be driven by a scripted or UART character source with no physical keyboard or USB bridge attached. Outputs are push-pull levels: idle high, driven low for zero bits.

---
 rtl/ascii_ps2_tx.sv | 256 +++++++++++++++++++++++++
 tb/tb_ascii_ps2_tx.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ascii_ps2_tx.sv
// ascii_ps2_tx: keyboard-side PS/2 transmitter.
// Each accepted ASCII character is sent as its Set-2 make/break sequence
// (M, F0, M), one 11-bit device frame per byte, with an idle gap between
// frames. Both PS/2 lines are push-pull and idle high.
// Optional feature: define ASCII_PS2_SHIFT_EN to send uppercase A-Z as
// 12, L, F0, L, F0, 12 (left shift around the letter). Without it,
// uppercase letters fold to lowercase.
module ascii_ps2_tx #(
  parameter int unsigned CLK_HZ  = 50_000_000,
  parameter int unsigned PS2_HZ  = 12_500,
  parameter int unsigned GAP_CYC = 10_000
) (
  input  logic       sys_clk,
  input  logic       reset,
  input  logic [7:0] ascii,
  input  logic       valid,
  output logic       ready,
  output logic       busy,
  output logic       unmapped,
  output logic       ps2_clk,
  output logic       ps2_data
);

  // Cycles per PS/2 clock phase; must be at least 2.
  localparam int unsigned HALF    = CLK_HZ / (2 * PS2_HZ);
  localparam int unsigned CNT_MAX = (HALF > GAP_CYC) ? HALF : GAP_CYC;
  localparam int unsigned CW      = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

`ifdef ASCII_PS2_SHIFT_EN
  localparam int unsigned SEQ_MAX = 6;
`else
  localparam int unsigned SEQ_MAX = 3;
`endif

  localparam logic [CW-1:0] HALF_LD  = CW'(HALF - 1);
  localparam logic [CW-1:0] GAP_LD   = CW'(GAP_CYC - 1);
  localparam logic [3:0]    LAST_BIT = 4'd10;
  localparam logic [7:0]    BRK_CODE = 8'hF0;
`ifdef ASCII_PS2_SHIFT_EN
  localparam logic [7:0]    LSHIFT   = 8'h12;
`endif

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LOAD   = 3'd1;
  localparam logic [2:0] BIT_HI = 3'd2;
  localparam logic [2:0] BIT_LO = 3'd3;
  localparam logic [2:0] GAP    = 3'd4;

  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [3:0]    bit_cnt;
  logic [3:0]    nxt_bit;
  logic [2:0]    idx;
  logic [2:0]    seq_last;
  logic [7:0]    ascii_q;
  logic [7:0]    seq_buf [SEQ_MAX];
  logic [7:0]    cur;
  logic [10:0]   frame;

  logic [7:0]    key;
  logic [7:0]    make;
  logic          hit;
`ifdef ASCII_PS2_SHIFT_EN
  logic          shifted;
`endif

  assign ready = (state == IDLE);
  assign busy  = (state != IDLE);

  // Fold case and look the captured character up in the Set-2 make table.
  always_comb begin
    key = ascii_q;
`ifdef ASCII_PS2_SHIFT_EN
    shifted = 1'b0;
`endif
    if (ascii_q >= 8'h41 && ascii_q <= 8'h5A) begin
      key = ascii_q | 8'h20;
`ifdef ASCII_PS2_SHIFT_EN
      shifted = 1'b1;
`endif
    end
    make = '0;
    hit  = 1'b1;
    case (key)
      8'h61: make = 8'h1C;  // a
      8'h62: make = 8'h32;  // b
      8'h63: make = 8'h21;  // c
      8'h64: make = 8'h23;  // d
      8'h65: make = 8'h24;  // e
      8'h66: make = 8'h2B;  // f
      8'h67: make = 8'h34;  // g
      8'h68: make = 8'h33;  // h
      8'h69: make = 8'h43;  // i
      8'h6A: make = 8'h3B;  // j
      8'h6B: make = 8'h42;  // k
      8'h6C: make = 8'h4B;  // l
      8'h6D: make = 8'h3A;  // m
      8'h6E: make = 8'h31;  // n
      8'h6F: make = 8'h44;  // o
      8'h70: make = 8'h4D;  // p
      8'h71: make = 8'h15;  // q
      8'h72: make = 8'h2D;  // r
      8'h73: make = 8'h1B;  // s
      8'h74: make = 8'h2C;  // t
      8'h75: make = 8'h3C;  // u
      8'h76: make = 8'h2A;  // v
      8'h77: make = 8'h1D;  // w
      8'h78: make = 8'h22;  // x
      8'h79: make = 8'h35;  // y
      8'h7A: make = 8'h1A;  // z
      8'h30: make = 8'h45;  // 0
      8'h31: make = 8'h16;  // 1
      8'h32: make = 8'h1E;  // 2
      8'h33: make = 8'h26;  // 3
      8'h34: make = 8'h25;  // 4
      8'h35: make = 8'h2E;  // 5
      8'h36: make = 8'h36;  // 6
      8'h37: make = 8'h3D;  // 7
      8'h38: make = 8'h3E;  // 8
      8'h39: make = 8'h46;  // 9
      8'h20: make = 8'h29;  // space
      8'h0D: make = 8'h5A;  // CR
      8'h08: make = 8'h66;  // BS
      default: begin
        make = '0;
        hit  = 1'b0;
      end
    endcase
  end

  // Select the byte currently being framed and build its 11-bit frame.
  always_comb begin
    cur = '0;
    for (int unsigned i = 0; i < SEQ_MAX; i++) begin
      if (idx == 3'(i)) cur = seq_buf[i];
    end
  end

  assign frame   = {1'b1, ~^cur, cur, 1'b0};
  assign nxt_bit = bit_cnt + 4'd1;

  // Fill the sequence buffer from the table during LOAD.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < SEQ_MAX; i++) seq_buf[i] <= '0;
      seq_last <= '0;
    end else if (state == LOAD && hit) begin
`ifdef ASCII_PS2_SHIFT_EN
      if (shifted) begin
        seq_buf[0] <= LSHIFT;
        seq_buf[1] <= make;
        seq_buf[2] <= BRK_CODE;
        seq_buf[3] <= make;
        seq_buf[4] <= BRK_CODE;
        seq_buf[5] <= LSHIFT;
        seq_last   <= 3'd5;
      end else begin
        seq_buf[0] <= make;
        seq_buf[1] <= BRK_CODE;
        seq_buf[2] <= make;
        seq_last   <= 3'd2;
      end
`else
      seq_buf[0] <= make;
      seq_buf[1] <= BRK_CODE;
      seq_buf[2] <= make;
      seq_last   <= 3'd2;
`endif
    end
  end

  // One-cycle pulse when LOAD finds no table entry.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) unmapped <= 1'b0;
    else       unmapped <= (state == LOAD) && !hit;
  end

  // Frame sequencer: phase timing, bit/byte stepping and PS/2 line drive.
  // ps2_data is only written on entry to BIT_HI or GAP, so it is stable
  // across every falling edge of ps2_clk.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_cnt  <= '0;
      idx      <= '0;
      ascii_q  <= '0;
      ps2_clk  <= 1'b1;
      ps2_data <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (valid) begin
            ascii_q <= ascii;
            state   <= LOAD;
          end
        end
        LOAD: begin
          if (hit) begin
            state    <= BIT_HI;
            cnt      <= HALF_LD;
            bit_cnt  <= '0;
            idx      <= '0;
            ps2_clk  <= 1'b1;
            ps2_data <= 1'b0;  // start bit
          end else begin
            state <= IDLE;
          end
        end
        BIT_HI: begin
          if (cnt == '0) begin
            state   <= BIT_LO;
            cnt     <= HALF_LD;
            ps2_clk <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        BIT_LO: begin
          if (cnt == '0) begin
            ps2_clk <= 1'b1;
            if (bit_cnt == LAST_BIT) begin
              state    <= GAP;
              cnt      <= GAP_LD;
              ps2_data <= 1'b1;
            end else begin
              state    <= BIT_HI;
              cnt      <= HALF_LD;
              bit_cnt  <= nxt_bit;
              ps2_data <= frame[nxt_bit];
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        GAP: begin
          if (cnt == '0) begin
            if (idx == seq_last) begin
              state <= IDLE;
            end else begin
              state    <= BIT_HI;
              cnt      <= HALF_LD;
              idx      <= idx + 3'd1;
              bit_cnt  <= '0;
              ps2_data <= 1'b0;  // start bit of the next byte
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ascii_ps2_tx.sv
// tb_ascii_ps2_tx: self-checking bench for ascii_ps2_tx (HALF=4, GAP_CYC=20).
// A host-style decoder samples ps2_data on each ps2_clk fall and rebuilds
// bytes; expectations come from a character/make-code table model.
module tb_ascii_ps2_tx;

  localparam int unsigned CLK_HZ    = 80;
  localparam int unsigned PS2_HZ    = 10;
  localparam int unsigned GAP_CYC   = 20;
  localparam int          HALF      = 4;
  localparam int          FRAME_CYC = 22 * HALF + GAP_CYC;

  logic       sys_clk = 1'b0;
  logic       reset;
  logic [7:0] ascii;
  logic       valid;
  logic       ready;
  logic       busy;
  logic       unmapped;
  logic       ps2_clk;
  logic       ps2_data;

  int checks   = 0;
  int failures = 0;

  logic [7:0]  rx_q  [$];
  logic        par_q [$];
  logic [7:0]  exp_q [$];
  int          frame_err = 0;
  int          fall_cnt  = 0;
  int          mon_bits  = 0;
  logic [10:0] mon_sr    = '0;

  string      keys = "abcdefghijklmnopqrstuvwxyz0123456789 \015\010";
  logic [7:0] mk_tab [39] = '{
    8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B,
    8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C,
    8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A,
    8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46,
    8'h29, 8'h5A, 8'h66};

  always #5 sys_clk = ~sys_clk;

  ascii_ps2_tx #(
    .CLK_HZ (CLK_HZ),
    .PS2_HZ (PS2_HZ),
    .GAP_CYC(GAP_CYC)
  ) dut (
    .sys_clk (sys_clk),
    .reset   (reset),
    .ascii   (ascii),
    .valid   (valid),
    .ready   (ready),
    .busy    (busy),
    .unmapped(unmapped),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data)
  );

  // Host-side frame decoder; a reset drops any partial frame.
  always @(negedge ps2_clk or posedge reset) begin
    if (reset) begin
      mon_bits = 0;
    end else begin
      fall_cnt++;
      mon_sr[mon_bits] = ps2_data;
      mon_bits++;
      if (mon_bits == 11) begin
        if (mon_sr[0] !== 1'b0 || mon_sr[10] !== 1'b1 ||
            (^mon_sr[9:1]) !== 1'b1) frame_err++;
        rx_q.push_back(mon_sr[8:1]);
        par_q.push_back(mon_sr[9]);
        mon_bits = 0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: make code for a character, -1 if it has none.
  function automatic int ref_make(input logic [7:0] c);
    for (int i = 0; i < 39; i++) if (keys[i] == c) return int'(mk_tab[i]);
    return -1;
  endfunction

  // Reference: byte sequence the transmitter should send for c.
  task automatic build_expected(input logic [7:0] c);
    int   m;
    logic up;
    exp_q.delete();
    up = (c >= 8'h41 && c <= 8'h5A);
    m  = ref_make(up ? (c + 8'h20) : c);
    if (m < 0) return;
`ifdef ASCII_PS2_SHIFT_EN
    if (up) begin
      exp_q = '{8'h12, m[7:0], 8'hF0, m[7:0], 8'hF0, 8'h12};
      return;
    end
`endif
    exp_q = '{m[7:0], 8'hF0, m[7:0]};
  endtask

  // Offer c and return at the falling edge one cycle after acceptance.
  task automatic accept_char(input logic [7:0] c);
    int n;
    n = 0;
    @(negedge sys_clk);
    while (!ready && n < 5000) begin
      @(negedge sys_clk);
      n++;
    end
    if (!ready) begin
      checks++; failures++;
      $display("FAIL accept_wait: ready=%0b required 1", ready);
    end
    ascii = c;
    valid = 1'b1;
    @(posedge sys_clk);
    @(negedge sys_clk);
    valid = 1'b0;
  endtask

  // Cycles from acceptance until ready is seen again (bounded).
  task automatic wait_ready(output int cyc);
    cyc = 1;
    while (!ready && cyc < 4000) begin
      @(negedge sys_clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge sys_clk);
    checks++; if (ps2_clk !== 1'b1)  begin failures++; $display("FAIL reset_clk: got %b want 1", ps2_clk); end
    checks++; if (ps2_data !== 1'b1) begin failures++; $display("FAIL reset_data: got %b want 1", ps2_data); end
    checks++; if (ready !== 1'b1)    begin failures++; $display("FAIL reset_ready: got %b want 1", ready); end
    checks++; if (busy !== 1'b0)     begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (unmapped !== 1'b0) begin failures++; $display("FAIL reset_unmapped: got %b want 0", unmapped); end
    reset = 1'b0;
    repeat (3) @(negedge sys_clk);
    checks++; if (ready !== 1'b1 || busy !== 1'b0 || ps2_clk !== 1'b1)
      begin failures++; $display("FAIL post_reset_idle: ready=%b busy=%b clk=%b want 1 0 1", ready, busy, ps2_clk); end
  endtask

  task automatic test_lowercase_a();
    int cyc;
    int first_fall;
    rx_q.delete(); par_q.delete();
    frame_err = 0;
    build_expected(8'h61);
    accept_char(8'h61);
    cyc = 1;
    first_fall = 0;
    while (!ready && cyc < 4000) begin
      @(negedge sys_clk);
      cyc++;
      if (cyc == 2) begin
        checks++;
        if (ps2_data !== 1'b0 || busy !== 1'b1 || ready !== 1'b0 || ps2_clk !== 1'b1) begin
          failures++;
          $display("FAIL a_start: data=%b busy=%b ready=%b clk=%b want 0 1 0 1", ps2_data, busy, ready, ps2_clk);
        end
      end
      if (first_fall == 0 && ps2_clk === 1'b0) first_fall = cyc;
    end
    checks++; if (first_fall != 2 + HALF) begin failures++; $display("FAIL a_first_fall: got %0d want %0d", first_fall, 2 + HALF); end
    checks++; if (cyc != 326) begin failures++; $display("FAIL a_ready_cycles: got %0d want 326", cyc); end
    checks++; if (rx_q.size() != 3) begin failures++; $display("FAIL a_frame_count: got %0d want 3", rx_q.size()); end
    else begin
      for (int i = 0; i < 3; i++) begin
        checks++; if (rx_q[i] !== exp_q[i]) begin failures++; $display("FAIL a_byte%0d: got %02h want %02h", i, rx_q[i], exp_q[i]); end
      end
      checks++; if (par_q[0] !== 1'b0 || par_q[1] !== 1'b1 || par_q[2] !== 1'b0)
        begin failures++; $display("FAIL a_parity: got %b%b%b want 010", par_q[0], par_q[1], par_q[2]); end
    end
    checks++; if (frame_err != 0) begin failures++; $display("FAIL a_frame_format: got %0d bad frames want 0", frame_err); end
  endtask

  task automatic test_uppercase();
    int cyc;
    rx_q.delete(); par_q.delete();
    frame_err = 0;
    build_expected(8'h41);
    accept_char(8'h41);
    wait_ready(cyc);
    checks++; if (cyc != 2 + exp_q.size() * FRAME_CYC)
      begin failures++; $display("FAIL A_ready_cycles: got %0d want %0d", cyc, 2 + exp_q.size() * FRAME_CYC); end
    checks++; if (rx_q.size() != exp_q.size()) begin failures++; $display("FAIL A_frame_count: got %0d want %0d", rx_q.size(), exp_q.size()); end
    else for (int i = 0; i < exp_q.size(); i++) begin
      checks++; if (rx_q[i] !== exp_q[i]) begin failures++; $display("FAIL A_byte%0d: got %02h want %02h", i, rx_q[i], exp_q[i]); end
    end
    checks++; if (frame_err != 0) begin failures++; $display("FAIL A_frame_format: got %0d bad frames want 0", frame_err); end
  endtask

  task automatic test_unmapped();
    int f0;
    int pulses;
    int pulse_cyc;
    int low_seen;
    f0 = fall_cnt;
    pulses = 0; pulse_cyc = 0; low_seen = 0;
    accept_char(8'h23);
    for (int k = 1; k <= 5; k++) begin
      if (k > 1) @(negedge sys_clk);
      if (unmapped === 1'b1) begin pulses++; pulse_cyc = k; end
      if (ps2_clk !== 1'b1 || ps2_data !== 1'b1) low_seen++;
      if (k == 2) begin
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL unmapped_ready: got %b want 1 at cycle 2", ready); end
      end
    end
    checks++; if (pulses != 1 || pulse_cyc != 2)
      begin failures++; $display("FAIL unmapped_pulse: got %0d pulses at cycle %0d want 1 at 2", pulses, pulse_cyc); end
    checks++; if (low_seen != 0 || fall_cnt != f0)
      begin failures++; $display("FAIL unmapped_lines: got %0d low cycles %0d falls want 0 0", low_seen, fall_cnt - f0); end
  endtask

  task automatic test_random();
    int         cyc;
    int         j;
    logic [7:0] c;
    for (int it = 0; it < 10; it++) begin
      j = int'($urandom_range(38, 0));
      c = keys[j];
      if (j < 26 && $urandom_range(1, 0) == 1) c = c - 8'h20;
      if ($urandom_range(3, 0) == 0) c = 8'($urandom_range(255, 0));
      build_expected(c);
      rx_q.delete();
      frame_err = 0;
      accept_char(c);
      wait_ready(cyc);
      if (exp_q.size() == 0) begin
        repeat (3) @(negedge sys_clk);
        checks++; if (cyc != 2 || rx_q.size() != 0)
          begin failures++; $display("FAIL rand_unmapped %02h: got %0d cycles %0d frames want 2 0", c, cyc, rx_q.size()); end
      end else begin
        checks++; if (cyc != 2 + exp_q.size() * FRAME_CYC)
          begin failures++; $display("FAIL rand_cycles %02h: got %0d want %0d", c, cyc, 2 + exp_q.size() * FRAME_CYC); end
        checks++; if (rx_q.size() != exp_q.size())
          begin failures++; $display("FAIL rand_count %02h: got %0d want %0d", c, rx_q.size(), exp_q.size()); end
        else for (int i = 0; i < exp_q.size(); i++) begin
          checks++; if (rx_q[i] !== exp_q[i])
            begin failures++; $display("FAIL rand_byte %02h[%0d]: got %02h want %02h", c, i, rx_q[i], exp_q[i]); end
        end
        checks++; if (frame_err != 0) begin failures++; $display("FAIL rand_format %02h: got %0d bad frames want 0", c, frame_err); end
      end
    end
  endtask

  task automatic test_back_to_back();
    int         cyc;
    int         cyc2;
    int         idle;
    int         first_idle;
    logic [7:0] exp6 [6];
    exp6 = '{8'h16, 8'hF0, 8'h16, 8'h1E, 8'hF0, 8'h1E};
    rx_q.delete();
    frame_err = 0;
    @(negedge sys_clk);
    ascii = 8'h31;
    valid = 1'b1;
    @(posedge sys_clk);
    @(negedge sys_clk);
    ascii = 8'h32;
    cyc = 1; idle = 0; first_idle = 0;
    while (cyc < 4000) begin
      @(negedge sys_clk);
      cyc++;
      if (ready === 1'b1) begin
        idle++;
        if (idle == 1) first_idle = cyc;
      end else if (idle > 0) begin
        break;
      end
    end
    valid = 1'b0;
    wait_ready(cyc2);
    checks++; if (first_idle != 326) begin failures++; $display("FAIL b2b_first_ready: got %0d want 326", first_idle); end
    checks++; if (idle != 1) begin failures++; $display("FAIL b2b_idle_cycles: got %0d want 1", idle); end
    checks++; if (cyc2 != 326) begin failures++; $display("FAIL b2b_second_cycles: got %0d want 326", cyc2); end
    checks++; if (rx_q.size() != 6) begin failures++; $display("FAIL b2b_count: got %0d want 6", rx_q.size()); end
    else for (int i = 0; i < 6; i++) begin
      checks++; if (rx_q[i] !== exp6[i]) begin failures++; $display("FAIL b2b_byte%0d: got %02h want %02h", i, rx_q[i], exp6[i]); end
    end
  endtask

  task automatic test_reset_midframe();
    int n;
    int cyc;
    rx_q.delete();
    frame_err = 0;
    accept_char(8'h7A);
    n = 0;
    while (!(mon_bits == 5 && ps2_clk === 1'b0) && n < 2000) begin
      @(negedge sys_clk);
      n++;
    end
    checks++; if (ps2_clk !== 1'b0) begin failures++; $display("FAIL mid_reach_bit3: got clk=%b bits=%0d want 0 5", ps2_clk, mon_bits); end
    reset = 1'b1;
    #1;
    checks++; if (ps2_clk !== 1'b1 || ps2_data !== 1'b1)
      begin failures++; $display("FAIL mid_reset_lines: got clk=%b data=%b want 1 1", ps2_clk, ps2_data); end
    checks++; if (ready !== 1'b1 || busy !== 1'b0)
      begin failures++; $display("FAIL mid_reset_state: got ready=%b busy=%b want 1 0", ready, busy); end
    @(negedge sys_clk);
    reset = 1'b0;
    repeat (200) @(negedge sys_clk);
    checks++; if (rx_q.size() != 0 || ready !== 1'b1 || ps2_clk !== 1'b1)
      begin failures++; $display("FAIL mid_after_release: got %0d frames ready=%b clk=%b want 0 1 1", rx_q.size(), ready, ps2_clk); end
    build_expected(8'h62);
    accept_char(8'h62);
    wait_ready(cyc);
    checks++; if (cyc != 326) begin failures++; $display("FAIL mid_b_cycles: got %0d want 326", cyc); end
    checks++; if (rx_q.size() != 3) begin failures++; $display("FAIL mid_b_count: got %0d want 3", rx_q.size()); end
    else for (int i = 0; i < 3; i++) begin
      checks++; if (rx_q[i] !== exp_q[i]) begin failures++; $display("FAIL mid_b_byte%0d: got %02h want %02h", i, rx_q[i], exp_q[i]); end
    end
    checks++; if (frame_err != 0) begin failures++; $display("FAIL mid_b_format: got %0d bad frames want 0", frame_err); end
  endtask

  task automatic test_loopback();
    int         cyc;
    logic [7:0] txt [4];
    logic [7:0] got [$];
    int         i;
    txt = '{8'h68, 8'h69, 8'h0D, 8'h08};
    rx_q.delete();
    frame_err = 0;
    for (int k = 0; k < 4; k++) begin
      accept_char(txt[k]);
      wait_ready(cyc);
    end
    // Receive-side decode: skip shift and break-prefixed codes, map makes.
    i = 0;
    while (i < rx_q.size()) begin
      if (rx_q[i] == 8'hF0) i += 2;
      else if (rx_q[i] == 8'h12) i++;
      else begin
        for (int j = 0; j < 39; j++) if (mk_tab[j] == rx_q[i]) got.push_back(keys[j]);
        i++;
      end
    end
    checks++; if (got.size() != 4) begin failures++; $display("FAIL loop_count: got %0d want 4", got.size()); end
    else for (int k = 0; k < 4; k++) begin
      checks++; if (got[k] !== txt[k]) begin failures++; $display("FAIL loop_char%0d: got %02h want %02h", k, got[k], txt[k]); end
    end
    checks++; if (frame_err != 0) begin failures++; $display("FAIL loop_format: got %0d bad frames want 0", frame_err); end
  endtask

  initial begin
    reset = 1'b1;
    valid = 1'b0;
    ascii = '0;
    test_reset();
    test_lowercase_a();
    test_uppercase();
    test_unmapped();
    test_random();
    test_back_to_back();
    test_reset_midframe();
    test_loopback();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
